// File: rtl/sprite_redraw.sv
// Sprite redraw engine: erases a SWxSH sprite at its previous position, then
// draws it at a new position, emitting one registered pixel per clock.
module sprite_redraw #(
  parameter int         SW        = 4,
  parameter int         SH        = 4,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] x_new,
  input  logic [6:0] y_new,
  input  logic [2:0] colour_in,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] DX_LAST = 3'(SW - 1);
  localparam logic [2:0] DY_LAST = 3'(SH - 1);

  state_t     state_r, state_nxt_s;
  logic [2:0] dx_r, dy_r, dx_nxt_s, dy_nxt_s;
  logic [7:0] new_x_r, old_x_r;
  logic [6:0] new_y_r, old_y_r;
  logic [2:0] new_c_r;
  logic       old_valid_r;

  logic [7:0] x_out_r;
  logic [6:0] y_out_r;
  logic [2:0] colour_out_r;
  logic       plot_r, busy_r, done_r;

  logic [7:0] base_x_s;
  logic [6:0] base_y_s;
  logic [2:0] pix_c_s;
  logic [8:0] sum_x_s;
  logic [7:0] sum_y_s;
  logic       on_screen_s;
  logic       last_pix_s;

  // Next-state and pixel counter sequencing.
  always_comb begin
    state_nxt_s = state_r;
    dx_nxt_s    = dx_r;
    dy_nxt_s    = dy_r;
    last_pix_s  = (dx_r == DX_LAST) && (dy_r == DY_LAST);
    case (state_r)
      IDLE: begin
        dx_nxt_s = 3'd0;
        dy_nxt_s = 3'd0;
        if (start) begin
          state_nxt_s = old_valid_r ? ERASE : DRAW;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ERASE, DRAW: begin
        if (last_pix_s) begin
          dx_nxt_s    = 3'd0;
          dy_nxt_s    = 3'd0;
          state_nxt_s = (state_r == ERASE) ? DRAW : DONE;
        end else if (dx_r == DX_LAST) begin
          dx_nxt_s = 3'd0;
          dy_nxt_s = dy_r + 3'd1;
        end else begin
          dx_nxt_s = dx_r + 3'd1;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        dx_nxt_s    = 3'd0;
        dy_nxt_s    = 3'd0;
      end
    endcase
  end

  // Current pixel address and colour; sums are one bit wider to catch off-screen.
  always_comb begin
    base_x_s = new_x_r;
    base_y_s = new_y_r;
    pix_c_s  = new_c_r;
    if (state_r == ERASE) begin
      base_x_s = old_x_r;
      base_y_s = old_y_r;
      pix_c_s  = BG_COLOUR;
    end else begin
      base_x_s = new_x_r;
      base_y_s = new_y_r;
      pix_c_s  = new_c_r;
    end
    sum_x_s     = {1'b0, base_x_s} + {6'b000000, dx_r};
    sum_y_s     = {1'b0, base_y_s} + {5'b00000, dy_r};
    on_screen_s = (sum_x_s <= 9'd159) && (sum_y_s <= 8'd119);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      dx_r    <= 3'd0;
      dy_r    <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      dx_r    <= dx_nxt_s;
      dy_r    <= dy_nxt_s;
    end
  end

  // Request capture in IDLE and old-position update on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      new_x_r     <= 8'd0;
      new_y_r     <= 7'd0;
      new_c_r     <= 3'd0;
      old_x_r     <= 8'd0;
      old_y_r     <= 7'd0;
      old_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            new_x_r <= x_new;
            new_y_r <= y_new;
            new_c_r <= colour_in;
          end
        end
        DONE: begin
          old_x_r     <= new_x_r;
          old_y_r     <= new_y_r;
          old_valid_r <= 1'b1;
        end
        default: begin
          old_valid_r <= old_valid_r;
        end
      endcase
    end
  end

  // Registered pixel, busy and done outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_out_r      <= 8'd0;
      y_out_r      <= 7'd0;
      colour_out_r <= 3'd0;
      plot_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          plot_r <= 1'b0;
          done_r <= 1'b0;
          busy_r <= start;
        end
        ERASE, DRAW: begin
          x_out_r      <= sum_x_s[7:0];
          y_out_r      <= sum_y_s[6:0];
          colour_out_r <= pix_c_s;
          plot_r       <= on_screen_s;
          done_r       <= 1'b0;
          busy_r       <= 1'b1;
        end
        DONE: begin
          plot_r <= 1'b0;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: begin
          plot_r <= 1'b0;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign x_out      = x_out_r;
  assign y_out      = y_out_r;
  assign colour_out = colour_out_r;
  assign plot       = plot_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
